// File: rtl/cmul_seq.sv
// Sequential conjugate complex multiply-accumulate: one shared 16x16 multiplier, four passes per sample.
// Define CMUL_SEQ_SAT_EN to saturate the combine and accumulate additions instead of wrapping.
module cmul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [31:0] input1,
    input  logic [31:0] input2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] o
);

    // state | meaning
    // IDLE  | accepting an operand pair
    // M0    | p0 = a*c
    // M1    | p1 = b*d
    // M2    | p2 = b*c
    // M3    | p3 = a*d, combine and accumulate
    // OUT   | presenting the burst sum until out_ready
    typedef enum logic [2:0] {
        S_IDLE,
        S_M0,
        S_M1,
        S_M2,
        S_M3,
        S_OUT
    } state_t;

`ifdef CMUL_SEQ_SAT_EN
    function automatic logic [15:0] add16(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] s;
        s = {x[15], x} + {y[15], y};
        if (s[16] != s[15]) add16 = s[16] ? 16'h8000 : 16'h7FFF;
        else                add16 = s[15:0];
    endfunction

    function automatic logic [15:0] sub16(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] s;
        s = {x[15], x} - {y[15], y};
        if (s[16] != s[15]) sub16 = s[16] ? 16'h8000 : 16'h7FFF;
        else                sub16 = s[15:0];
    endfunction
`else
    function automatic logic [15:0] add16(input logic [15:0] x, input logic [15:0] y);
        add16 = x + y;
    endfunction

    function automatic logic [15:0] sub16(input logic [15:0] x, input logic [15:0] y);
        sub16 = x - y;
    endfunction
`endif

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic        last_q, last_d;
    logic [15:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
    logic [15:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] o_q, o_d;

    logic signed [15:0] mul_x, mul_y, mul_lo;
    logic [15:0]        sum_re, sum_im;

    always_comb begin
        mul_x = a_q;
        mul_y = c_q;
        case (state_q)
            S_M1:    begin mul_x = b_q; mul_y = d_q; end
            S_M2:    begin mul_x = b_q; mul_y = c_q; end
            S_M3:    begin mul_x = a_q; mul_y = d_q; end
            default: begin mul_x = a_q; mul_y = c_q; end
        endcase
    end

    // Only the low half of the product is ever used, which is the 32-bit signed product mod 2^16.
    assign mul_lo = mul_x * mul_y;
    assign sum_re = add16(p0_q, p1_q);
    assign sum_im = sub16(p2_q, mul_lo);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        d_d      = d_q;
        last_d   = last_q;
        p0_d     = p0_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        o_d      = o_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = input1[31:16];
                    b_d     = input1[15:0];
                    c_d     = input2[31:16];
                    d_d     = input2[15:0];
                    last_d  = in_last;
                    state_d = S_M0;
                end
            end
            S_M0: begin
                p0_d    = mul_lo;
                state_d = S_M1;
            end
            S_M1: begin
                p1_d    = mul_lo;
                state_d = S_M2;
            end
            S_M2: begin
                p2_d    = mul_lo;
                state_d = S_M3;
            end
            S_M3: begin
                acc_re_d = add16(acc_re_q, sum_re);
                acc_im_d = add16(acc_im_q, sum_im);
                if (last_q) begin
                    o_d     = {acc_re_d, acc_im_d};
                    state_d = S_OUT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    acc_re_d = 16'h0000;
                    acc_im_d = 16'h0000;
                    o_d      = 32'h0000_0000;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            c_q         <= 16'h0000;
            d_q         <= 16'h0000;
            last_q      <= 1'b0;
            p0_q        <= 16'h0000;
            p1_q        <= 16'h0000;
            p2_q        <= 16'h0000;
            acc_re_q    <= 16'h0000;
            acc_im_q    <= 16'h0000;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            o_q         <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            last_q      <= last_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            acc_re_q    <= acc_re_d;
            acc_im_q    <= acc_im_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            o_q         <= o_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign o         = o_q;

endmodule

// File: doc/cmul_seq.md
# cmul_seq

Time-multiplexed conjugate complex multiply-accumulate controller. It sequences one shared 16x16 signed multiplier over four cycles to compute (a+bi)*(c-di) on packed 32-bit complex operands, accumulates the results over a burst, and emits the sum at the burst's last sample. It sits beside the four-multiplier parallel complex multiplier as the area-reduced alternative for correlation and dot-product paths, where throughput of one sample per five cycles is sufficient.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- in_last  in  1  sampled with the operands; marks the final sample of a burst
- input1  in  32  {a[31:16] = re, b[15:0] = im}, signed
- input2  in  32  {c[31:16] = re, d[15:0] = im}, signed
- out_valid  out  1  accumulated result valid
- out_ready  in  1  downstream accepts the result
- o  out  32  {acc_re[31:16], acc_im[15:0]}, signed

## Operation
- States: IDLE, M0, M1, M2, M3, OUT.
- IDLE: in_ready=1. On in_valid&in_ready, latch a, b, c, d and in_last, then go to M0.
- M0..M3 each perform one multiply on the single shared multiplier:
  - M0: p0 = a*c
  - M1: p1 = b*d
  - M2: p2 = b*c
  - M3: p3 = a*d
- Each product is the low 16 bits of the signed 32-bit product (two's-complement wrap).
- End of M3:
  - acc_re <= acc_re + (p0 + p1)
  - acc_im <= acc_im + (p2 - p3)
- Intermediate sums and accumulation are 16-bit. They wrap unless saturation is enabled (see Configuration).
- After M3: latched last=1 goes to OUT; otherwise back to IDLE with the accumulator retained.
- OUT: out_valid=1 and o = {acc_re, acc_im}, held stable until out_ready. On out_valid&out_ready, clear the accumulator to 0 and go to IDLE.
- in_ready=0 in every state except IDLE. in_last is ignored unless in_valid&in_ready.
- Burst length is unbounded. A single-sample burst (in_last=1 on the first sample) is legal.

## Timing
- Reset values:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - o = 0x0000_0000
  - acc_re = acc_im = 0
  - all latched operands = 0
- rst asserted in any state, including mid-multiply or in OUT with out_valid high: the next cycle is IDLE with the reset values above, and the partial burst is discarded.
- Handshake at edge k → M0 in cycle k+1, M3 in cycle k+4, accumulator updated at the end of k+4.
- If last, out_valid is high from cycle k+5. Minimum input-to-output latency is 5 cycles.
- Throughput: one sample per 5 cycles; one extra cycle per burst for the OUT handshake when out_ready=1 on arrival.
- out_valid&out_ready in cycle j → in_ready=1 in cycle j+1. There is no same-cycle bypass from OUT to accept.
- o is registered and changes only at the end of M3 of a last sample, or on the clear after output.
- Outside OUT, o holds its last value. Consumers qualify it with out_valid.

## Configuration
- CMUL_SEQ_SAT_EN defined:
  - (p0+p1), (p2-p3) and both accumulator additions saturate to [0x8000, 0x7FFF].
  - Individual products still wrap.
- Not defined: all additions wrap modulo 2^16, bit-identical to the parallel multiplier's combine.

## Test plan
- Single sample, last=1: input1=0x0003_0002, input2=0x0004_0005 → out_valid at k+5, o=0x0016_FFF9 (22, -7).
- Two-sample burst: (0x0003_0002, 0x0004_0005, last=0) then (0x0001_0001, 0x0001_0001, last=1) → one output, o=0x0018_FFF9. out_valid stays low after the first sample.
- Saturation: input1=input2=0x00B5_00B5, last=1 → o=0x7FFF_0000 with CMUL_SEQ_SAT_EN, o=0xFFF2_0000 without.
- Backpressure: hold out_ready=0 for 3 cycles in OUT → o and out_valid stable, in_ready=0, in_valid ignored. After the handshake, the next burst starts from a zero accumulator.
- Reset mid-operation: assert rst during M2 of a burst's second sample → next cycle IDLE, in_ready=1, out_valid=0. A following single sample 0x0003_0002/0x0004_0005 yields 0x0016_FFF9 (no stale accumulation).
- Handshake gating: hold in_valid=1 continuously → accepts exactly one sample per 5 cycles, and in_ready is high only in IDLE.
